stopwatch_key_ctrl: RTL and testbench

//  Upstream control stage for the stopwatch counter chain. Synchronises and debounces two
//  raw active-low board keys: S5 is clear and S6 is start/stop. A start/pause/clear state

---
 rtl/stopwatch_key_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_stopwatch_key_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_key_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_key_ctrl
//
// Upstream control stage for the stopwatch counter chain. Two raw active-low
// board keys (S5 = clear, S6 = start/stop) are synchronised, debounced and
// turned into single-cycle events. Those events drive a start/pause/clear
// state machine. The machine produces a run-enable level and a stretched
// clear pulse that every digit counter shares, so all digits start, stop and
// clear together.
//
// Optional feature, selected by the macro KEY_LONGPRESS_CLEAR_EN:
//   defined   - S6 toggles run/pause on release, and only when the hold was
//               shorter than LONG_CYCLES. Holding S6 for LONG_CYCLES raises
//               one clear event. The FSM acts on that event only in
//               IDLE/PAUSE. The release that ends a long hold produces nothing.
//   undefined - S6 toggles on press. S5 is the only clear source, and no
//               long-press counter is built.
//
// Parameters
//   DEB_CYCLES   cp cycles a key level must stay stable before it is accepted
//   CLR_CYCLES   cp cycles clr is held high in the CLEAR state
//   LONG_CYCLES  cp cycles of S6 hold that count as a long press
//
// Ports
//   cp         in   system clock; every flop uses its rising edge
//   reset      in   synchronous reset, active-low
//   key_clr_n  in   raw S5 key, asynchronous, 0 = pressed
//   key_run_n  in   raw S6 key, asynchronous, 0 = pressed
//   run        out  1 = counters advance, 0 = counters hold
//   clr        out  1 = clear all digit counters
//   state      out  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR
//
// Timing: the FSM is registered, and run/clr decode directly from the state
// register. A clean press therefore shows up on the outputs
// 2 (sync) + DEB_CYCLES (debounce) + 1 (event register) + 1 (state register)
// cp edges after the first edge that samples the key low.
// -----------------------------------------------------------------------------
module stopwatch_key_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int CLR_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic       cp,
  input  logic       reset,
  input  logic       key_clr_n,
  input  logic       key_run_n,
  output logic       run,
  output logic       clr,
  output logic [1:0] state
);

  // Counter widths. Each counter has at least one bit, so a parameter of 1
  // still elaborates.
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  // Reject nonsensical configurations at elaboration time.
  if (DEB_CYCLES < 1 || CLR_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
    $error("stopwatch_key_ctrl: DEB_CYCLES, CLR_CYCLES and LONG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-key synchroniser and debouncer.
  // Index 0 is S5 (clear) and index 1 is S6 (run).
  // ---------------------------------------------------------------------------
  logic [1:0] raw_n;
  logic [1:0] deb_lvl;   // debounced level, 1 = released
  logic [1:0] deb_prev;  // debounced level one cycle earlier

  assign raw_n = {key_run_n, key_clr_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge cp) begin
      if (!reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= 1'b1;
        deb_d_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_n[k];
        sync2_q <= sync1_q;
        deb_d_q <= deb_q;
        // The counter runs only while the synced key disagrees with the
        // accepted level. Any agreement restarts it, so a bounce shorter than
        // DEB_CYCLES never reaches the terminal count.
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign deb_lvl[k]  = deb_q;
    assign deb_prev[k] = deb_d_q;
  end

  // ---------------------------------------------------------------------------
  // Event generation. Events are registered one cycle behind the debounced
  // edge, so the FSM sees clean single-cycle pulses.
  // ---------------------------------------------------------------------------
  logic run_evt_q;
  logic clr_evt_q;

`ifdef KEY_LONGPRESS_CLEAR_EN
  // The counter holds the number of cycles S6 has been debounced-pressed. It
  // saturates at LONG_CYCLES, so at release time it shows whether the hold was
  // long.
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_HIT = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q;
  logic              clr_fall;
  logic              run_rise;
  logic              long_hit;

  assign clr_fall = deb_prev[0] & ~deb_lvl[0];
  assign run_rise = ~deb_prev[1] & deb_lvl[1];
  // Counting stops at LONG_MAX, so the counter holds LONG_HIT for exactly one
  // cycle per hold. That gives a single clear event.
  assign long_hit = ~deb_lvl[1] && (long_cnt_q == LONG_HIT);

  always_ff @(posedge cp) begin
    if (!reset) begin
      long_cnt_q <= '0;
      run_evt_q  <= 1'b0;
      clr_evt_q  <= 1'b0;
    end else begin
      if (deb_lvl[1]) begin
        long_cnt_q <= '0;
      end else if (long_cnt_q != LONG_MAX) begin
        long_cnt_q <= long_cnt_q + 1'b1;
      end
      // On the release cycle the counter still holds the length of the hold.
      run_evt_q <= run_rise && (long_cnt_q != LONG_MAX);
      clr_evt_q <= clr_fall || long_hit;
    end
  end
`else
  always_ff @(posedge cp) begin
    if (!reset) begin
      run_evt_q <= 1'b0;
      clr_evt_q <= 1'b0;
    end else begin
      run_evt_q <= deb_prev[1] & ~deb_lvl[1];
      clr_evt_q <= deb_prev[0] & ~deb_lvl[0];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Start / pause / clear state machine
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_nxt;
  logic [CLR_W-1:0] clr_cnt_q;

  always_ff @(posedge cp) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // The counter measures time spent in CLEAR and sits at zero everywhere else.
  // A reset during CLEAR returns it to zero along with the state.
  always_ff @(posedge cp) begin
    if (!reset) begin
      clr_cnt_q <= '0;
    end else if (state_q == S_CLEAR && clr_cnt_q != CLR_LAST) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end else begin
      clr_cnt_q <= '0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      // Clear wins over a simultaneous run event.
      S_IDLE, S_PAUSE: begin
        if (clr_evt_q) begin
          state_nxt = S_CLEAR;
        end else if (run_evt_q) begin
          state_nxt = S_RUN;
        end
      end
      // Clear is ignored while running, and a simultaneous clear is dropped.
      S_RUN: begin
        if (run_evt_q) begin
          state_nxt = S_PAUSE;
        end
      end
      // Every event is ignored until the clear pulse has been fully stretched.
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign run   = (state_q == S_RUN);
  assign clr   = (state_q == S_CLEAR);
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_key_ctrl
//
// Directed bench for stopwatch_key_ctrl with DEB_CYCLES=4, CLR_CYCLES=3 and
// LONG_CYCLES=10.
//
// A behavioural model follows the rules in plain terms:
//   - the debounced level flips once the last DEB_CYCLES synchronised samples
//     all disagree with it;
//   - an event acts on the state two edges after its debounced edge;
//   - CLEAR lasts CLR_CYCLES cycles;
//   - hold length is measured from press and release cycle stamps.
// A compare process checks state/run/clr against the model on every cycle
// after the first reset. Literal checks at chosen points pin the model itself.
// Define KEY_LONGPRESS_CLEAR_EN to build and test the long-press variant.
// -----------------------------------------------------------------------------
module tb_stopwatch_key_ctrl;

  localparam int DEB   = 4;
  localparam int CLRN  = 3;
  localparam int LONGN = 10;

  logic       cp;
  logic       reset;
  logic       key_clr_n;
  logic       key_run_n;
  logic       run;
  logic       clr;
  logic [1:0] state;

  int checks    = 0;
  int errors    = 0;
  int clr_seen  = 0;
  bit chk_en    = 1'b0;

  stopwatch_key_ctrl #(
    .DEB_CYCLES  (DEB),
    .CLR_CYCLES  (CLRN),
    .LONG_CYCLES (LONGN)
  ) dut (
    .cp        (cp),
    .reset     (reset),
    .key_clr_n (key_clr_n),
    .key_run_n (key_run_n),
    .run       (run),
    .clr       (clr),
    .state     (state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial cp = 1'b0;
  always #5 cp = ~cp;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [1:0]     m_state;
  int             m_clr_left;
  logic [1:0]     m_pipe_run, m_pipe_clr;   // two-stage synchroniser delay
  logic [DEB-1:0] m_win_run, m_win_clr;     // last DEB synchronised samples
  logic           m_deb_run, m_deb_clr;
  logic [1:0]     m_ev_run, m_ev_clr;       // [0] newest, [1] acts now
  int             m_cyc;
  int             m_press_cyc;

  always @(posedge cp) begin : model
    logic s_run, s_clr, now_run, now_clr;
    if (!reset) begin
      m_state     = 2'b00;
      m_clr_left  = 0;
      m_pipe_run  = 2'b11;
      m_pipe_clr  = 2'b11;
      m_win_run   = '1;
      m_win_clr   = '1;
      m_deb_run   = 1'b1;
      m_deb_clr   = 1'b1;
      m_ev_run    = 2'b00;
      m_ev_clr    = 2'b00;
      m_cyc       = 0;
      m_press_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
      // The state acts on events whose debounced edge came two edges ago.
      case (m_state)
        2'b00, 2'b10: begin
          if (m_ev_clr[1]) begin
            m_state    = 2'b11;
            m_clr_left = CLRN;
          end else if (m_ev_run[1]) begin
            m_state = 2'b01;
          end
        end
        2'b01: if (m_ev_run[1]) m_state = 2'b10;
        default: begin
          m_clr_left = m_clr_left - 1;
          if (m_clr_left == 0) m_state = 2'b00;
        end
      endcase
      m_ev_run[1] = m_ev_run[0];
      m_ev_clr[1] = m_ev_clr[0];

      s_run      = m_pipe_run[1];
      s_clr      = m_pipe_clr[1];
      m_pipe_run = {m_pipe_run[0], key_run_n};
      m_pipe_clr = {m_pipe_clr[0], key_clr_n};
      m_win_run  = {m_win_run[DEB-2:0], s_run};
      m_win_clr  = {m_win_clr[DEB-2:0], s_clr};

      now_run = 1'b0;
      now_clr = 1'b0;
      if (m_win_clr == {DEB{~m_deb_clr}}) begin
        m_deb_clr = ~m_deb_clr;
        if (!m_deb_clr) now_clr = 1'b1;
      end
      if (m_win_run == {DEB{~m_deb_run}}) begin
        m_deb_run = ~m_deb_run;
`ifdef KEY_LONGPRESS_CLEAR_EN
        if (!m_deb_run) m_press_cyc = m_cyc;
        else if (m_cyc - m_press_cyc < LONGN) now_run = 1'b1;
`else
        if (!m_deb_run) now_run = 1'b1;
`endif
      end
`ifdef KEY_LONGPRESS_CLEAR_EN
      if (!m_deb_run && (m_cyc - m_press_cyc == LONGN - 1)) now_clr = 1'b1;
`endif
      m_ev_run[0] = now_run;
      m_ev_clr[0] = now_clr;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and clr-cycle monitor
  // ---------------------------------------------------------------------------
  always @(posedge cp) begin
    #1;
    if (clr === 1'b1) clr_seen = clr_seen + 1;
    if (chk_en) begin
      checks = checks + 1;
      if (state !== m_state || run !== (m_state == 2'b01) || clr !== (m_state == 2'b11)) begin
        errors = errors + 1;
        $display("FAIL cycle_cmp t=%0t got state=%b run=%b clr=%b want state=%b run=%b clr=%b",
                 $time, state, run, clr, m_state, (m_state == 2'b01), (m_state == 2'b11));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver and literal-check tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge cp);
  endtask

  task automatic check_lit(input string name, input logic [1:0] st,
                           input logic r, input logic c);
    checks = checks + 1;
    if (state !== st || run !== r || clr !== c) begin
      errors = errors + 1;
      $display("FAIL %s got state=%b run=%b clr=%b want state=%b run=%b clr=%b",
               name, state, run, clr, st, r, c);
    end
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Press the selected keys together, hold them, release, then let things settle.
  task automatic press(input logic do_clr, input logic do_run, input int hold);
    @(negedge cp);
    if (do_clr) key_clr_n = 1'b0;
    if (do_run) key_run_n = 1'b0;
    step(hold);
    key_clr_n = 1'b1;
    key_run_n = 1'b1;
    step(16);
  endtask

  task automatic do_reset();
    @(negedge cp);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b0;
    key_clr_n = 1'b1;
    key_run_n = 1'b1;

    // 1. Reset
    step(2);
    check_lit("reset", 2'b00, 1'b0, 1'b0);
    chk_en = 1'b1;
    reset  = 1'b1;
    step(2);

    // 2. Bounce on S6 followed by a steady press
    for (int i = 0; i < 12; i++) begin
      key_run_n = ((i % 4) < 2) ? 1'b0 : 1'b1;
      step(1);
    end
    key_run_n = 1'b0;
`ifndef KEY_LONGPRESS_CLEAR_EN
    step(7);
    check_lit("bounce_latency_minus1", 2'b00, 1'b0, 1'b0);
    step(1);
    check_lit("bounce_latency", 2'b01, 1'b1, 1'b0);
    step(2);
`else
    step(6);
`endif
    key_run_n = 1'b1;
    step(16);
    check_lit("bounce_single_start", 2'b01, 1'b1, 1'b0);

    // 3. Start / pause / resume from IDLE
    do_reset();
    check_lit("reset_from_run", 2'b00, 1'b0, 1'b0);
    press(1'b0, 1'b1, 6);
    check_lit("start", 2'b01, 1'b1, 1'b0);
    press(1'b0, 1'b1, 6);
    check_lit("pause", 2'b10, 1'b0, 1'b0);
    press(1'b0, 1'b1, 6);
    check_lit("resume", 2'b01, 1'b1, 1'b0);

    // 4. Clear is ignored in RUN and honoured in PAUSE
    clr_seen = 0;
    press(1'b1, 1'b0, 6);
    check_lit("clr_in_run", 2'b01, 1'b1, 1'b0);
    check_cnt("clr_in_run_cycles", clr_seen, 0);
    press(1'b0, 1'b1, 6);
    check_lit("pause_before_clr", 2'b10, 1'b0, 1'b0);
    clr_seen = 0;
    press(1'b1, 1'b0, 6);
    check_cnt("clr_pulse_cycles", clr_seen, CLRN);
    check_lit("after_clear", 2'b00, 1'b0, 1'b0);

    // Reset in the middle of CLEAR aborts it
    press(1'b0, 1'b1, 6);
    press(1'b0, 1'b1, 6);
    @(negedge cp);
    key_clr_n = 1'b0;
    step(5);
    key_clr_n = 1'b1;
    step(4);
    check_lit("mid_clear", 2'b11, 1'b0, 1'b1);
    reset = 1'b0;
    step(1);
    check_lit("clear_abort", 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    step(2);

    // 5. Both keys together: in RUN -> PAUSE, in PAUSE -> CLEAR
    press(1'b0, 1'b1, 6);
    clr_seen = 0;
    press(1'b1, 1'b1, 6);
    check_lit("both_in_run", 2'b10, 1'b0, 1'b0);
    check_cnt("both_in_run_clr_cycles", clr_seen, 0);
    clr_seen = 0;
    press(1'b1, 1'b1, 6);
    check_cnt("both_in_pause_clr_cycles", clr_seen, CLRN);

`ifdef KEY_LONGPRESS_CLEAR_EN
    // 6. Long press of S6 in PAUSE clears; a short press toggles on release
    do_reset();
    press(1'b0, 1'b1, 6);
    press(1'b0, 1'b1, 6);
    check_lit("lp_pause", 2'b10, 1'b0, 1'b0);
    clr_seen = 0;
    press(1'b0, 1'b1, 12);
    check_cnt("lp_clr_cycles", clr_seen, CLRN);
    check_lit("lp_release_no_toggle", 2'b00, 1'b0, 1'b0);
    press(1'b0, 1'b1, 5);
    press(1'b0, 1'b1, 5);
    check_lit("lp_pause_again", 2'b10, 1'b0, 1'b0);
    @(negedge cp);
    key_run_n = 1'b0;
    step(5);
    key_run_n = 1'b1;
    step(4);
    check_lit("short_hold_no_toggle_yet", 2'b10, 1'b0, 1'b0);
    step(10);
    check_lit("short_hold_toggle_on_release", 2'b01, 1'b1, 1'b0);
`endif

    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
